// File: rtl/meta_stream_scheduler_pkg.sv
// meta_stream_scheduler_pkg: shared state encoding, default parameters and index-width helper
package meta_stream_scheduler_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ARB = 2'd1, XFER = 2'd2} state_t;
  localparam int DEF_DW = 128;
  localparam int DEF_NUM_SRC = 4;
  localparam int DEF_MAX_BEATS = 16;
  localparam int DEF_CW = 16;
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/meta_stream_scheduler_rr_pick.sv
// rr_pick: combinational round-robin priority encoder, searching upward from last+1 with wrap
module rr_pick
  import meta_stream_scheduler_pkg::*;
#(
  parameter int N = DEF_NUM_SRC,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          any,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] c;
  // walk offsets from farthest to nearest so the nearest valid requester wins
  always_comb begin
    any = 1'b0;
    idx = '0;
    c = '0;
    for (int i = N; i >= 1; i--) begin
      c = IW'((int'(last) + i) % N);
      if (req[c]) begin
        any = 1'b1;
        idx = c;
      end
    end
  end
endmodule

// File: rtl/meta_stream_scheduler.sv
// meta_stream_scheduler: packet-granular round-robin arbiter sharing one AXI-stream among NUM_SRC generators
module meta_stream_scheduler
  import meta_stream_scheduler_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int NUM_SRC = DEF_NUM_SRC,
  parameter int MAX_BEATS = DEF_MAX_BEATS,
  parameter int CW = DEF_CW,
  localparam int IW = clog2(NUM_SRC)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  output logic [NUM_SRC-1:0]    src_start,
  input  logic [NUM_SRC*DW-1:0] src_tdata,
  input  logic [NUM_SRC-1:0]    src_tvalid,
  input  logic [NUM_SRC-1:0]    src_tlast,
  output logic [NUM_SRC-1:0]    src_tready,
  output logic [DW-1:0]         axis_out_tdata,
  output logic                  axis_out_tvalid,
  output logic                  axis_out_tlast,
  output logic [IW-1:0]         axis_out_tid,
  input  logic                  axis_out_tready,
  output logic [CW-1:0]         pkt_count,
  output logic                  overrun,
  output logic                  busy
);
  localparam int BW = clog2(MAX_BEATS + 1);
  state_t state, state_next;
  logic [IW-1:0] grant, last_grant, pick_idx;
  logic [BW-1:0] beat_cnt;
  logic pick_any, xfer, sv, sl, forced, beat, done;

  rr_pick #(.N(NUM_SRC), .IW(IW)) u_pick (
    .req(src_tvalid),
    .last(last_grant),
    .any(pick_any),
    .idx(pick_idx)
  );

  assign xfer = state == XFER;
  assign sv = src_tvalid[grant];
  assign sl = src_tlast[grant];
  assign forced = xfer && beat_cnt == BW'(MAX_BEATS - 1) && sv && !sl;
  assign beat = xfer && sv && axis_out_tready;
  assign done = beat && axis_out_tlast;

  assign axis_out_tvalid = xfer && sv;
  assign axis_out_tlast = xfer && (sl || forced);
  assign axis_out_tdata = xfer ? src_tdata[int'(grant)*DW +: DW] : '0;
  assign axis_out_tid = xfer ? grant : '0;
  assign src_tready = xfer ? (NUM_SRC'(axis_out_tready) << grant) : '0;
  assign busy = state != IDLE;

  always_comb begin
    state_next = state;
    src_start = '0;
    unique case (state)
      IDLE: if (enable) begin
        state_next = ARB;
        src_start = '1;
      end
      ARB: state_next = !enable ? IDLE : pick_any ? XFER : ARB;
      XFER: if (done) state_next = enable ? ARB : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant <= '0;
      last_grant <= IW'(NUM_SRC - 1);
      beat_cnt <= '0;
      pkt_count <= '0;
      overrun <= 1'b0;
    end else begin
      if (state == ARB && enable && pick_any) begin
        grant <= pick_idx;
        beat_cnt <= '0;
      end
      if (beat) beat_cnt <= beat_cnt + 1'b1;
      if (done) begin
        pkt_count <= pkt_count + 1'b1;
        last_grant <= grant;
        overrun <= overrun | forced;
      end
    end
  end
endmodule

// File: tb/tb_meta_stream_scheduler.sv
// tb_meta_stream_scheduler: random and directed stimulus checked against a packet-level reference model
module tb_meta_stream_scheduler;
  localparam int N = 4;
  localparam int DW = 128;
  localparam int MAXB = 16;

  typedef struct packed {logic [DW-1:0] d; logic l;} beat_t;

  logic clk = 1'b0;
  logic reset, enable, out_ready;
  logic [N-1:0] src_start, src_tvalid, src_tlast, src_tready;
  logic [N*DW-1:0] src_tdata;
  logic [DW-1:0] axis_out_tdata;
  logic axis_out_tvalid, axis_out_tlast, overrun, busy;
  logic [1:0] axis_out_tid;
  logic [15:0] pkt_count;

  beat_t q[N][$];
  int passes = 0, total = 0;
  int ms, mg, mn, ml, mpkt;
  bit movr;

  always #5 clk = ~clk;

  meta_stream_scheduler dut (
    .clk(clk), .reset(reset), .enable(enable), .src_start(src_start),
    .src_tdata(src_tdata), .src_tvalid(src_tvalid), .src_tlast(src_tlast),
    .src_tready(src_tready), .axis_out_tdata(axis_out_tdata),
    .axis_out_tvalid(axis_out_tvalid), .axis_out_tlast(axis_out_tlast),
    .axis_out_tid(axis_out_tid), .axis_out_tready(out_ready),
    .pkt_count(pkt_count), .overrun(overrun), .busy(busy)
  );

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got === exp) passes++;
    else $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
  endtask

  task automatic model_reset();
    ms = 0; mg = 0; mn = 0; ml = N - 1; mpkt = 0; movr = 0;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      src_tvalid[i] = 1'b0;
      src_tlast[i] = 1'b0;
      src_tdata[i*DW +: DW] = '0;
      if (q[i].size() > 0) begin
        src_tvalid[i] = 1'b1;
        src_tlast[i] = q[i][0].l;
        src_tdata[i*DW +: DW] = q[i][0].d;
      end
    end
  endtask

  task automatic push(input int s, input int len, input bit term);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.d = {$urandom, $urandom, $urandom, $urandom};
      b.l = term && k == len - 1;
      q[s].push_back(b);
    end
    drive();
  endtask

  // ms: 0 idle, 1 arbitrating, 2 moving a packet from source mg with mn beats done
  task automatic step();
    logic ev, hs, frc, etl;
    logic [DW-1:0] ed;
    logic [N-1:0] pop;
    @(negedge clk);
    ev = ms == 2 && src_tvalid[mg];
    frc = ev && mn == MAXB - 1 && !src_tlast[mg];
    etl = ms == 2 && (src_tlast[mg] || frc);
    ed = ms == 2 ? src_tdata[mg*DW +: DW] : '0;
    check("tvalid", axis_out_tvalid, ev);
    check("tlast", axis_out_tlast, etl);
    check("tdata", axis_out_tdata, ed);
    check("tid", axis_out_tid, ms == 2 ? mg : 0);
    check("src_tready", src_tready, ms == 2 ? (N'(out_ready) << mg) : 0);
    check("src_start", src_start, (ms == 0 && enable) ? 4'hf : 4'h0);
    check("busy", busy, ms != 0);
    check("pkt_count", pkt_count, mpkt % 65536);
    check("overrun", overrun, movr);
    pop = src_tready & src_tvalid;
    hs = ev && out_ready;
    case (ms)
      0: if (enable) ms = 1;
      1: if (!enable) ms = 0;
         else for (int k = 1; k <= N; k++)
           if (ms == 1 && src_tvalid[(ml + k) % N]) begin
             mg = (ml + k) % N; mn = 0; ms = 2;
           end
      default: begin
        if (hs) mn++;
        if (hs && etl) begin
          mpkt++; ml = mg; movr |= frc; ms = enable ? 1 : 0;
        end
      end
    endcase
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (pop[i]) void'(q[i].pop_front());
    drive();
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; out_ready = 1'b0;
    src_tvalid = '0; src_tlast = '0; src_tdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) step();
    enable = 1'b1;
    repeat (4) step();
    out_ready = 1'b1;
    push(0, 3, 1); push(2, 3, 1);
    repeat (12) step();
    for (int r = 0; r < 2; r++) for (int s = 0; s < N; s++) push(s, 2, 1);
    repeat (30) step();
    push(1, 20, 0); push(1, 1, 1); push(2, 2, 1);
    repeat (40) step();
    push(3, 6, 1);
    for (int k = 0; k < 10 && ms != 2; k++) step();
    foreach (q[k]) ;
    out_ready = 1'b1; step(); out_ready = 1'b0; step(); step(); out_ready = 1'b1; step();
    repeat (6) step();
    push(0, 4, 1);
    for (int k = 0; k < 10 && ms != 2; k++) step();
    step(); enable = 1'b0;
    repeat (8) step();
    enable = 1'b1;
    push(3, 10, 1);
    for (int k = 0; k < 10 && ms != 2; k++) step();
    repeat (2) step();
    #2 reset = 1'b1;
    #1;
    check("rst_tvalid", axis_out_tvalid, 0);
    check("rst_src_tready", src_tready, 0);
    check("rst_pkt_count", pkt_count, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) step();
    for (int c = 0; c < 3000; c++) begin
      enable = $urandom_range(0, 19) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      for (int s = 0; s < N; s++) begin
        if (q[s].size() < 6 && $urandom_range(0, 7) == 0) push(s, $urandom_range(1, 6), 1);
        if (q[s].size() < 6 && $urandom_range(0, 199) == 0) push(s, $urandom_range(17, 22), 0);
      end
      step();
    end
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule

// File: doc/meta_stream_scheduler.md
Name: meta_stream_scheduler

Overview:
- Packet-granular round-robin scheduler that shares one AXI-stream output among NUM_SRC metadata packet generators.
- Pulses each generator's start input when enabled, then arbitrates the generators' streams.
- Grants one source per packet and holds the grant until that packet's tlast.
- Sits between the generator bank and the downstream packet sink.

Parameters:
- DW, 128, stream data width in bits.
- NUM_SRC, 4, number of generator sources (range 2..8).
- MAX_BEATS, 16, beat limit per packet before tlast is forced.
- CW, 16, width of the packet counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous reset, active-high; all state cleared.
- enable  in  1  level; scheduler runs while high.
- src_start  out  NUM_SRC  one-cycle start pulse to every generator.
- src_tdata  in  NUM_SRC*DW  source data, concatenated; source i occupies bits [i*DW +: DW].
- src_tvalid  in  NUM_SRC  source valid.
- src_tlast  in  NUM_SRC  source end-of-packet.
- src_tready  out  NUM_SRC  ready back to sources.
- axis_out_tdata  out  DW  muxed data.
- axis_out_tvalid  out  1  muxed valid.
- axis_out_tlast  out  1  muxed or forced tlast.
- axis_out_tid  out  clog2(NUM_SRC)  index of the granted source.
- axis_out_tready  in  1  downstream ready.
- pkt_count  out  CW  completed packets; wraps at 2^CW.
- overrun  out  1  sticky flag: a tlast was forced.
- busy  out  1  high when state is not IDLE.

Behaviour:
- Reset values:
  - state = IDLE; grant = 0; last_grant = NUM_SRC-1, so source 0 has first priority.
  - beat_cnt = 0; pkt_count = 0; overrun = 0.
  - src_start = 0; src_tready = 0; axis_out_tvalid = 0.
- State IDLE:
  - All outputs idle.
  - On enable=1: go to ARB and drive src_start = all-ones for exactly that one clk edge transition.
- State ARB:
  - Search src_tvalid starting at (last_grant+1) mod NUM_SRC, ascending with wrap.
  - First valid index found: register it as grant, clear beat_cnt, go to XFER. First beat can transfer on the next cycle, so grant latency is 1 cycle.
  - No valid source: stay in ARB.
  - enable=0: go to IDLE. enable takes priority over a pending request.
  - Outputs are idle in ARB: axis_out_tvalid = 0 and src_tready = 0.
- State XFER (output path is combinational from the grant register):
  - axis_out_tdata/tvalid/tlast = src_*[grant]; axis_out_tid = grant.
  - src_tready[grant] = axis_out_tready; all other src_tready bits = 0.
- Beat accounting: each beat with tvalid & tready increments beat_cnt.
- Forced tlast:
  - Condition: beat_cnt == MAX_BEATS-1, the source tlast is low, and source tvalid is high.
  - axis_out_tlast is forced to 1 on that beat; overrun is set sticky when the beat completes.
  - Source beats that follow belong to the next arbitration.
- Packet end (tlast handshake, forced or natural):
  - pkt_count increments; last_grant = grant.
  - Next state is ARB if enable=1, else IDLE.
- Mid-packet enable=0: the current packet completes; no truncation.
- Stall: if axis_out_tready=0 while valid is high, all of data, tlast and tid stay stable. This follows from the source holding its data per AXIS rules.
- Reset asserted mid-packet: immediate return to IDLE. Packets are not resumed.
- Counter wrap: pkt_count wraps from 2^CW-1 to 0 silently.
- Exiting to IDLE and re-enabling issues a new src_start pulse.

Decomposition:
- Shared package:
  - State encoding: IDLE=0, ARB=1, XFER=2.
  - Default parameter constants.
  - Index-width function clog2.
- One sub-module: rr_pick. It is a combinational round-robin priority encoder.
  - Inputs: req[NUM_SRC] and last[clog2 width].
  - Outputs: any and idx.
- Grant register, FSM, counters and output mux stay in the top module.

Test Plan:
1. Reset then enable=1, all sources idle -> src_start=4'b1111 for one cycle; busy=1; state held in ARB; axis_out_tvalid=0.
2. Sources 0 and 2 each present a 3-beat packet, axis_out_tready=1 -> grant src0 first, then src2; tid sequence 0,0,0,2,2,2; pkt_count=2; one idle ARB cycle between packets.
3. All four sources continuously valid with 2-beat packets -> packet order 0,1,2,3,0; pkt_count=5 after 5 packets.
4. Source 1 sends 20 beats with no tlast, MAX_BEATS=16 -> tlast forced on beat 16; overrun=1; next grant goes to the next requester.
5. axis_out_tready toggled 1,0,0,1 mid-packet -> tdata/tlast/tid stable during the stall; src_tready[grant] mirrors ready; other src_tready bits stay 0.
6. enable dropped on beat 2 of a 4-beat packet -> packet completes, then IDLE. Reset asserted mid-XFER -> outputs zero asynchronously; pkt_count=0.
